// File: rtl/rename_status_regfile.sv
// rename_status_regfile: architectural register file with per-register rename
// status (busy + producing ROB tag). Decode renames destinations and reads two
// sources per cycle; the ROB commit port writes results back and clears busy.
// ROB tags start at 1, so tag 0 means "no producer".
// Optional feature macro: RETIRE_COUNT_EN adds a 64-bit retire_count output
// that counts every commit strobe, including commits to x0.
// Interface: there is no valid/ready handshake anywhere in this block.
// rename_en and commit_we are one-cycle strobes that are always accepted. The
// ROB guarantees at most one commit per cycle.
module rename_status_regfile #(
   parameter int ROB_ENTRY_WIDTH = 8,
   parameter int XLEN            = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [4:0]                 rs1_addr,
   output logic                       rs1_busy,
   output logic [ROB_ENTRY_WIDTH-1:0] rs1_tag,
   output logic [XLEN-1:0]            rs1_data,
   input  logic [4:0]                 rs2_addr,
   output logic                       rs2_busy,
   output logic [ROB_ENTRY_WIDTH-1:0] rs2_tag,
   output logic [XLEN-1:0]            rs2_data,
   input  logic                       rename_en,
   input  logic [4:0]                 rename_rd,
   input  logic [ROB_ENTRY_WIDTH-1:0] rename_tag,
   input  logic                       commit_we,
   input  logic [4:0]                 commit_addr,
   input  logic [XLEN-1:0]            commit_data,
   input  logic [ROB_ENTRY_WIDTH-1:0] commit_tag,
   input  logic                       flush
`ifdef RETIRE_COUNT_EN
   ,
   output logic [63:0]                retire_count
`endif
);

   // x0 has no storage; it is hard-wired to 0 / not busy / tag 0.
   logic [XLEN-1:0]            regs_q [31:1];
   logic [XLEN-1:0]            regs_d [31:1];
   logic                       busy_q [31:1];
   logic                       busy_d [31:1];
   logic [ROB_ENTRY_WIDTH-1:0] tag_q  [31:1];
   logic [ROB_ENTRY_WIDTH-1:0] tag_d  [31:1];

   // Source 1 read: state, or the retiring value when the commit matches the producer.
   always_comb begin
      rs1_busy = 1'b0;
      rs1_tag  = '0;
      rs1_data = '0;
      if (rs1_addr != 5'd0) begin
         if (commit_we && (commit_addr == rs1_addr) && busy_q[rs1_addr] &&
             (tag_q[rs1_addr] == commit_tag)) begin
            rs1_data = commit_data;
         end else begin
            rs1_busy = busy_q[rs1_addr];
            rs1_tag  = tag_q[rs1_addr];
            rs1_data = regs_q[rs1_addr];
         end
      end
   end

   // Source 2 read: identical bypass rules to source 1.
   always_comb begin
      rs2_busy = 1'b0;
      rs2_tag  = '0;
      rs2_data = '0;
      if (rs2_addr != 5'd0) begin
         if (commit_we && (commit_addr == rs2_addr) && busy_q[rs2_addr] &&
             (tag_q[rs2_addr] == commit_tag)) begin
            rs2_data = commit_data;
         end else begin
            rs2_busy = busy_q[rs2_addr];
            rs2_tag  = tag_q[rs2_addr];
            rs2_data = regs_q[rs2_addr];
         end
      end
   end

   // Next state: commit first, then flush or rename, so a same-register rename
   // overrides the commit's busy clear and flush overrides everything but data.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      if (commit_we && (commit_addr != 5'd0)) begin
         regs_d[commit_addr] = commit_data;
         // A commit from an older producer must not clear a newer rename.
         if (busy_q[commit_addr] && (tag_q[commit_addr] == commit_tag)) begin
            busy_d[commit_addr] = 1'b0;
            tag_d[commit_addr]  = '0;
         end
      end
      if (flush) begin
         for (int i = 1; i < 32; i++) begin
            busy_d[i] = 1'b0;
            tag_d[i]  = '0;
         end
      end else if (rename_en && (rename_rd != 5'd0) && (rename_tag != '0)) begin
         busy_d[rename_rd] = 1'b1;
         tag_d[rename_rd]  = rename_tag;
      end
   end

   // State registers; reset wipes values and rename status immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i < 32; i++) begin
            regs_q[i] <= '0;
            busy_q[i] <= 1'b0;
            tag_q[i]  <= '0;
         end
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         tag_q  <= tag_d;
      end
   end

`ifdef RETIRE_COUNT_EN
   logic [63:0] retire_cnt_q;
   logic [63:0] retire_cnt_d;

   // Every commit strobe retires one instruction, x0 destinations included.
   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (commit_we) begin
         retire_cnt_d = retire_cnt_q + 64'd1;
      end
   end

   // Retire counter register; wraps naturally at 2^64.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retire_cnt_q <= '0;
      end else begin
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_rename_status_regfile.sv
// tb_rename_status_regfile: directed checks for rename_status_regfile.
// Inputs change on the falling edge; combinational outputs are sampled 1ns
// later, well away from the rising edge. Each scenario task checks inline.
module tb_rename_status_regfile;

  localparam int TW = 8;
  localparam int XW = 32;

  logic          clk;
  logic          rst;
  logic [4:0]    rs1_addr;
  logic          rs1_busy;
  logic [TW-1:0] rs1_tag;
  logic [XW-1:0] rs1_data;
  logic [4:0]    rs2_addr;
  logic          rs2_busy;
  logic [TW-1:0] rs2_tag;
  logic [XW-1:0] rs2_data;
  logic          rename_en;
  logic [4:0]    rename_rd;
  logic [TW-1:0] rename_tag;
  logic          commit_we;
  logic [4:0]    commit_addr;
  logic [XW-1:0] commit_data;
  logic [TW-1:0] commit_tag;
  logic          flush;
`ifdef RETIRE_COUNT_EN
  logic [63:0]   retire_count;
`endif

  int checks = 0;
  int errors = 0;

  rename_status_regfile #(.ROB_ENTRY_WIDTH(TW), .XLEN(XW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1_addr),
    .rs1_busy    (rs1_busy),
    .rs1_tag     (rs1_tag),
    .rs1_data    (rs1_data),
    .rs2_addr    (rs2_addr),
    .rs2_busy    (rs2_busy),
    .rs2_tag     (rs2_tag),
    .rs2_data    (rs2_data),
    .rename_en   (rename_en),
    .rename_rd   (rename_rd),
    .rename_tag  (rename_tag),
    .commit_we   (commit_we),
    .commit_addr (commit_addr),
    .commit_data (commit_data),
    .commit_tag  (commit_tag),
    .flush       (flush)
`ifdef RETIRE_COUNT_EN
    ,
    .retire_count(retire_count)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    rename_en   = 1'b0;
    rename_rd   = '0;
    rename_tag  = '0;
    commit_we   = 1'b0;
    commit_addr = '0;
    commit_data = '0;
    commit_tag  = '0;
    flush       = 1'b0;
  endtask

  // One rising edge, then back to the falling edge where inputs change.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_rename(input logic [4:0] rd, input logic [TW-1:0] tag);
    rename_en  = 1'b1;
    rename_rd  = rd;
    rename_tag = tag;
  endtask

  task automatic drive_commit(input logic [4:0] a, input logic [TW-1:0] tag, input logic [XW-1:0] d);
    commit_we   = 1'b1;
    commit_addr = a;
    commit_tag  = tag;
    commit_data = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rs1_addr = 5'd5;
    rs2_addr = 5'd0;
    rst = 1'b0;
    #1;
    checks++;
    if ({rs1_busy, rs1_tag, rs1_data} !== {1'b0, 8'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_hold_x5: got busy=%0b tag=%0d data=%h, expected 0/0/0", rs1_busy, rs1_tag, rs1_data);
    end
    step();
    rst = 1'b1;
    step();
    #1;
    checks++;
    if ({rs1_busy, rs1_tag, rs1_data} !== {1'b0, 8'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_x5: got busy=%0b tag=%0d data=%h, expected 0/0/0", rs1_busy, rs1_tag, rs1_data);
    end
    checks++;
    if ({rs2_busy, rs2_tag, rs2_data} !== {1'b0, 8'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_x0: got busy=%0b tag=%0d data=%h, expected 0/0/0", rs2_busy, rs2_tag, rs2_data);
    end
  endtask

  task automatic test_rename_commit();
    rs1_addr = 5'd3;
    drive_rename(5'd3, 8'd4);
    #1;
    checks++;
    if (rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL rename_same_cycle_hidden: got busy=%0b, expected 0", rs1_busy);
    end
    step();
    idle();
    #1;
    checks++;
    if ({rs1_busy, rs1_tag} !== {1'b1, 8'd4}) begin
      errors++;
      $display("FAIL rename_x3: got busy=%0b tag=%0d, expected 1/4", rs1_busy, rs1_tag);
    end
    drive_commit(5'd3, 8'd4, 32'hDEAD_BEEF);
    #1;
    checks++;
    if ({rs1_busy, rs1_tag, rs1_data} !== {1'b0, 8'd0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL commit_bypass_x3: got busy=%0b tag=%0d data=%h, expected 0/0/deadbeef", rs1_busy, rs1_tag, rs1_data);
    end
    step();
    idle();
    #1;
    checks++;
    if ({rs1_busy, rs1_tag, rs1_data} !== {1'b0, 8'd0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL commit_state_x3: got busy=%0b tag=%0d data=%h, expected 0/0/deadbeef", rs1_busy, rs1_tag, rs1_data);
    end
  endtask

  task automatic test_stale_commit();
    rs2_addr = 5'd7;
    drive_rename(5'd7, 8'd2);
    step();
    drive_rename(5'd7, 8'd5);
    step();
    idle();
    drive_commit(5'd7, 8'd2, 32'h11);
    #1;
    checks++;
    if ({rs2_busy, rs2_tag} !== {1'b1, 8'd5}) begin
      errors++;
      $display("FAIL stale_no_bypass: got busy=%0b tag=%0d, expected 1/5", rs2_busy, rs2_tag);
    end
    step();
    idle();
    #1;
    checks++;
    if ({rs2_busy, rs2_tag, rs2_data} !== {1'b1, 8'd5, 32'h11}) begin
      errors++;
      $display("FAIL stale_state: got busy=%0b tag=%0d data=%h, expected 1/5/11", rs2_busy, rs2_tag, rs2_data);
    end
    drive_commit(5'd7, 8'd5, 32'h22);
    #1;
    checks++;
    if ({rs2_busy, rs2_tag, rs2_data} !== {1'b0, 8'd0, 32'h22}) begin
      errors++;
      $display("FAIL fresh_bypass: got busy=%0b tag=%0d data=%h, expected 0/0/22", rs2_busy, rs2_tag, rs2_data);
    end
    step();
    idle();
    #1;
    checks++;
    if ({rs2_busy, rs2_tag, rs2_data} !== {1'b0, 8'd0, 32'h22}) begin
      errors++;
      $display("FAIL fresh_state: got busy=%0b tag=%0d data=%h, expected 0/0/22", rs2_busy, rs2_tag, rs2_data);
    end
  endtask

  task automatic test_back_to_back();
    rs1_addr = 5'd9;
    drive_commit(5'd9, 8'd1, 32'h33);
    drive_rename(5'd9, 8'd6);
    #1;
    // x9 is not busy, so the commit is not bypassed: old value 0 still visible.
    checks++;
    if ({rs1_busy, rs1_data} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL same_cycle_read: got busy=%0b data=%h, expected 0/0", rs1_busy, rs1_data);
    end
    step();
    idle();
    #1;
    checks++;
    if ({rs1_busy, rs1_tag, rs1_data} !== {1'b1, 8'd6, 32'h33}) begin
      errors++;
      $display("FAIL rename_wins: got busy=%0b tag=%0d data=%h, expected 1/6/33", rs1_busy, rs1_tag, rs1_data);
    end
    drive_commit(5'd9, 8'd6, 32'h44);
    step();
    idle();
    #1;
    checks++;
    if ({rs1_busy, rs1_tag, rs1_data} !== {1'b0, 8'd0, 32'h44}) begin
      errors++;
      $display("FAIL commit_after_rename: got busy=%0b tag=%0d data=%h, expected 0/0/44", rs1_busy, rs1_tag, rs1_data);
    end
  endtask

  task automatic test_x0_and_zero_tag();
    rs1_addr = 5'd0;
    rs2_addr = 5'd10;
    drive_rename(5'd0, 8'd3);
    drive_commit(5'd0, 8'd3, 32'h55);
    #1;
    checks++;
    if ({rs1_busy, rs1_tag, rs1_data} !== {1'b0, 8'd0, 32'd0}) begin
      errors++;
      $display("FAIL x0_same_cycle: got busy=%0b tag=%0d data=%h, expected 0/0/0", rs1_busy, rs1_tag, rs1_data);
    end
    step();
    idle();
    drive_rename(5'd10, 8'd0);
    #1;
    checks++;
    if ({rs1_busy, rs1_tag, rs1_data} !== {1'b0, 8'd0, 32'd0}) begin
      errors++;
      $display("FAIL x0_after: got busy=%0b tag=%0d data=%h, expected 0/0/0", rs1_busy, rs1_tag, rs1_data);
    end
    step();
    idle();
    #1;
    checks++;
    if ({rs2_busy, rs2_tag} !== {1'b0, 8'd0}) begin
      errors++;
      $display("FAIL rename_tag0_ignored: got busy=%0b tag=%0d, expected 0/0", rs2_busy, rs2_tag);
    end
  endtask

  task automatic test_flush();
    logic [XW-1:0] exp_q[$];
    // Give x1..x4 known committed values, then rename them (tags 11..14).
    for (int i = 1; i <= 4; i++) begin
      drive_commit(i[4:0], 8'd1, 32'hA0 + i);
      exp_q.push_back(32'hA0 + i);
      step();
    end
    idle();
    for (int i = 1; i <= 4; i++) begin
      drive_rename(i[4:0], 8'(10 + i));
      step();
    end
    idle();
    rs1_addr = 5'd2;
    #1;
    checks++;
    if ({rs1_busy, rs1_tag} !== {1'b1, 8'd12}) begin
      errors++;
      $display("FAIL pre_flush_x2: got busy=%0b tag=%0d, expected 1/12", rs1_busy, rs1_tag);
    end
    // Flush with a dropped rename of x5 and a stale commit to x4 that still writes.
    flush = 1'b1;
    drive_rename(5'd5, 8'd21);
    drive_commit(5'd4, 8'd99, 32'hB4);
    void'(exp_q.pop_back());
    exp_q.push_back(32'hB4);
    step();
    idle();
    for (int i = 1; i <= 4; i++) begin
      logic [XW-1:0] exp_d;
      rs1_addr = i[4:0];
      exp_d = exp_q.pop_front();
      #1;
      checks++;
      if ({rs1_busy, rs1_tag, rs1_data} !== {1'b0, 8'd0, exp_d}) begin
        errors++;
        $display("FAIL flush_x%0d: got busy=%0b tag=%0d data=%h, expected 0/0/%h", i, rs1_busy, rs1_tag, rs1_data, exp_d);
      end
    end
    rs2_addr = 5'd5;
    #0.5;
    checks++;
    if (rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_drops_rename: got busy=%0b, expected 0", rs2_busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle();
    rs1_addr = 5'd6;
    drive_rename(5'd6, 8'd7);
    drive_commit(5'd9, 8'd0, 32'h66);
    step();
    idle();
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({rs1_busy, rs1_tag} !== {1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid_busy: got busy=%0b tag=%0d, expected 0/0", rs1_busy, rs1_tag);
    end
    rs1_addr = 5'd9;
    #1;
    checks++;
    if (rs1_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_data: got data=%h, expected 0", rs1_data);
    end
    step();
    rst = 1'b1;
    step();
  endtask

`ifdef RETIRE_COUNT_EN
  task automatic test_retire_count();
    apply_reset();
    checks++;
    if (retire_count !== 64'd0) begin
      errors++;
      $display("FAIL retire_after_reset: got %0d, expected 0", retire_count);
    end
    for (int i = 0; i < 10; i++) begin
      drive_commit((i == 4) ? 5'd0 : 5'(i + 1), 8'd1, 32'(i));
      step();
    end
    idle();
    #1;
    checks++;
    if (retire_count !== 64'd10) begin
      errors++;
      $display("FAIL retire_count_10: got %0d, expected 10", retire_count);
    end
    drive_commit(5'd3, 8'd1, 32'h1);
    step();
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (retire_count !== 64'd0) begin
      errors++;
      $display("FAIL retire_mid_reset: got %0d, expected 0", retire_count);
    end
    idle();
    step();
    rst = 1'b1;
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    rs1_addr = '0;
    rs2_addr = '0;
    idle();
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_back_to_back();
    test_x0_and_zero_tag();
    test_flush();
    test_reset_mid();
`ifdef RETIRE_COUNT_EN
    test_retire_count();
`endif
    apply_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
